// File: rtl/my_bitwise_pkg.sv
// Shared definitions for the two-requester bitwise OR/AND arbiter.
package my_bitwise_pkg;

    // Operand and result width.
    localparam int WORD_W = 16;

    // Operation encoding carried on reqN_op.
    localparam logic OP_OR  = 1'b0;
    localparam logic OP_AND = 1'b1;

    // IDLE: no result held. HOLD: result held and resp_valid is high.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/my_or_16.sv
// 16-bit bitwise OR gate vector.
module my_or_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    assign y = a | b;

endmodule

// File: rtl/my_rr_arb_2.sv
// Two-way round-robin arbiter. It produces a one-hot grant, gated by accept,
// and remembers the last granted requester so ties alternate.
module my_rr_arb_2 #(
    parameter logic FIRST_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    // Requester that was granted most recently. Its reset value is the
    // opposite of FIRST_PRIO, so FIRST_PRIO wins the first tie.
    logic last;
    logic pick1;

    // Choose a winner. On a tie the requester not granted last wins.
    always_comb begin
        grant = 2'b00;
        pick1 = valid[1] && (!valid[0] || (last == 1'b0));
        if (accept) begin
            if (pick1) begin
                grant = 2'b10;
            end else if (valid[0]) begin
                grant = 2'b01;
            end
        end
    end

    // Move the pointer only when a transfer actually happens. A requester
    // that drops valid before it is granted never reaches this point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= ~FIRST_PRIO;
        end else if (grant[1]) begin
            last <= 1'b1;
        end else if (grant[0]) begin
            last <= 1'b0;
        end
    end

endmodule

// File: rtl/my_bitwise_arbiter.sv
// Two requesters share a single 16-bit OR/AND unit. At most one operation
// is accepted per cycle. The result is registered and offered on a
// valid/ready response port with one cycle of latency.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both high. reqN_ready is combinational and depends on reqN_valid.
// resp_valid stays high and resp_id/resp_out stay stable until resp_ready
// is sampled high.
module my_bitwise_arbiter
    import my_bitwise_pkg::*;
#(
    parameter int FIRST_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_op,
    input  logic [WORD_W-1:0] req0_a,
    input  logic [WORD_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_op,
    input  logic [WORD_W-1:0] req1_a,
    input  logic [WORD_W-1:0] req1_b,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [WORD_W-1:0] resp_out,
    input  logic              resp_ready
);

    state_t            state;
    state_t            state_next;
    logic              accept_en;
    logic [1:0]        grant;
    logic              accepted;
    logic              sel_id;
    logic              sel_op;
    logic [WORD_W-1:0] sel_a;
    logic [WORD_W-1:0] sel_b;
    logic [WORD_W-1:0] or_res;
    logic [WORD_W-1:0] and_res;
    logic [WORD_W-1:0] result;

    // A new operation can enter when nothing is held, or when the held
    // result leaves this cycle. Reset is included so both readies stay low
    // while reset is asserted.
    assign accept_en = !reset && ((state == IDLE) || ((state == HOLD) && resp_ready));

    my_rr_arb_2 #(
        .FIRST_PRIO (FIRST_PRIO != 0)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid  ({req1_valid, req0_valid}),
        .accept (accept_en),
        .grant  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accepted   = |grant;

    // Route the granted requester's operands into the shared unit.
    always_comb begin
        sel_id = grant[1];
        sel_op = grant[1] ? req1_op : req0_op;
        sel_a  = grant[1] ? req1_a  : req0_a;
        sel_b  = grant[1] ? req1_b  : req0_b;
    end

    my_or_16 u_or (
        .a (sel_a),
        .b (sel_b),
        .y (or_res)
    );

    assign and_res = sel_a & sel_b;
    assign result  = (sel_op == OP_AND) ? and_res : or_res;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state. resp_ready is ignored in IDLE. In HOLD, a consumed result
    // either makes room for a back-to-back acceptance or drops to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accepted) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (resp_ready) begin
                    state_next = accepted ? HOLD : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the result and owner only on the accepting edge. Later operand
    // changes therefore cannot disturb a held response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_out <= '0;
            resp_id  <= 1'b0;
        end else if (accepted) begin
            resp_out <= result;
            resp_id  <= sel_id;
        end
    end

    assign resp_valid = (state == HOLD);

endmodule

// File: tb/tb_my_bitwise_arbiter.sv
// Self-checking bench for my_bitwise_arbiter: a reference model of the
// arbitration and response scoreboard, plus directed reset checks.
module tb_my_bitwise_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic        req0_ready;
    logic        req0_op;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic        req1_op;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        resp_valid;
    logic        resp_id;
    logic [15:0] resp_out;
    logic        resp_ready;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Expected responses: {id, result}.
    logic [16:0] exp_q[$];

    // Reference model state.
    logic m_hold;
    logic m_last;

    my_bitwise_arbiter #(
        .FIRST_PRIO (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_out   (resp_out),
        .resp_ready (resp_ready)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic op, input logic [15:0] a, input logic [15:0] b);
        return op ? (a & b) : (a | b);
    endfunction

    // Drive one cycle of stimulus just after the rising edge.
    task automatic drive(input logic v0, input logic op0, input logic [15:0] a0, input logic [15:0] b0,
                         input logic v1, input logic op1, input logic [15:0] a1, input logic [15:0] b1,
                         input logic rr);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        resp_ready = rr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        end
    endtask

    // Asynchronous reset pulse spanning one falling edge, with checks taken
    // before any clock edge has passed.
    task automatic pulse_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_resp_out", 32'(resp_out), 32'h0000);
        check_val("rst_resp_id", 32'(resp_id), 32'd0);
        check_val("rst_req0_ready", 32'(req0_ready), 32'd0);
        check_val("rst_req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    // Monitor on the falling edge: compare readies and the response with the
    // model, then advance the model to what the next rising edge will do.
    initial begin
        logic acc_en;
        logic win1;
        logic e_r0;
        logic e_r1;
        m_hold = 1'b0;
        m_last = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_hold = 1'b0;
                m_last = 1'b1;
                exp_q.delete();
            end else begin
                acc_en = !m_hold || resp_ready;
                win1   = req1_valid && (!req0_valid || (m_last == 1'b0));
                e_r1   = acc_en && win1;
                e_r0   = acc_en && req0_valid && !win1;
                check_val("req0_ready", 32'(req0_ready), 32'(e_r0));
                check_val("req1_ready", 32'(req1_ready), 32'(e_r1));
                check_val("resp_valid", 32'(resp_valid), 32'(m_hold));
                if (m_hold) begin
                    if (exp_q.size() == 0) begin
                        check_val("resp_unexpected", 32'd1, 32'd0);
                    end else begin
                        check_val("resp_id", 32'(resp_id), 32'(exp_q[0][16]));
                        check_val("resp_out", 32'(resp_out), 32'(exp_q[0][15:0]));
                        if (resp_ready) begin
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (e_r0) begin
                    exp_q.push_back({1'b0, ref_op(req0_op, req0_a, req0_b)});
                    m_last = 1'b0;
                end else if (e_r1) begin
                    exp_q.push_back({1'b1, ref_op(req1_op, req1_a, req1_b)});
                    m_last = 1'b1;
                end
                if (e_r0 || e_r1) begin
                    m_hold = 1'b1;
                end else if (resp_ready) begin
                    m_hold = 1'b0;
                end
            end
        end
    end

    // Stimulus.
    initial begin
        reset      = 1'b1;
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 16'h0; req0_b = 16'h0;
        req1_valid = 1'b1; req1_op = 1'b0; req1_a = 16'h0; req1_b = 16'h0;
        resp_ready = 1'b0;
        #2;
        check_val("init_resp_valid", 32'(resp_valid), 32'd0);
        check_val("init_resp_out", 32'(resp_out), 32'h0000);
        check_val("init_ready0", 32'(req0_ready), 32'd0);
        check_val("init_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        idle(1);

        // Single requester, OR.
        drive(1'b1, 1'b0, 16'hE000, 16'h000C, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        #1;
        check_val("single_ready0", 32'(req0_ready), 32'd1);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        #1;
        check_val("single_resp_out", 32'(resp_out), 32'hE00C);
        check_val("single_resp_id", 32'(resp_id), 32'd0);
        idle(2);

        // First tie after reset goes to requester 0, then requester 1.
        pulse_reset();
        drive(1'b1, 1'b1, 16'hFFFF, 16'h00F0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b1);
        drive(1'b0, 1'b1, 16'hFFFF, 16'h00F0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b1);
        #1;
        check_val("tie_first_out", 32'(resp_out), 32'h00F0);
        check_val("tie_first_id", 32'(resp_id), 32'd0);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        #1;
        check_val("tie_second_out", 32'(resp_out), 32'hFFFF);
        check_val("tie_second_id", 32'(resp_id), 32'd1);
        idle(2);

        // Sustained tie alternates owners.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 16'(i), 16'h0100, 1'b1, 1'b1, 16'hFF00, 16'(16'h0F0F + i), 1'b1);
        end
        idle(3);

        // Back-pressure: held result stays put, nobody is accepted.
        drive(1'b1, 1'b1, 16'h3C3C, 16'h0FF0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 16'h1200, 16'h0034, 1'b1, 1'b1, 16'hABCD, 16'hF0F0, 1'b0);
        end
        drive(1'b1, 1'b0, 16'h1200, 16'h0034, 1'b1, 1'b1, 16'hABCD, 16'hF0F0, 1'b1);
        drive(1'b1, 1'b0, 16'h1200, 16'h0034, 1'b1, 1'b1, 16'hABCD, 16'hF0F0, 1'b1);
        idle(3);

        // Reset while holding A5A5 discards it; next tie goes to requester 0.
        drive(1'b1, 1'b0, 16'hA500, 16'h00A5, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        #1;
        check_val("hold_a5a5", 32'(resp_out), 32'hA5A5);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        pulse_reset();
        #1;
        check_val("post_rst_ready0", 32'(req0_ready), 32'd1);
        check_val("post_rst_ready1", 32'(req1_ready), 32'd0);
        idle(3);

        // Operands change after acceptance; the held result keeps the old ones.
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h1111, 16'h0F0F, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'hFFFF, 16'h0F0F, 1'b0);
        #1;
        check_val("sample_out", 32'(resp_out), 32'h0101);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'hFFFF, 16'h0F0F, 1'b1);
        idle(2);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 3) != 0));
        end
        idle(4);
        @(negedge clk);
        #1;
        check_val("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/my_bitwise_arbiter.md
MY_BITWISE_ARBITER -- requirements
Module: my_bitwise_arbiter

Interface
REQ-001 Parameter: FIRST_PRIO, 0, requester that wins the first tie after reset (0 or 1).
REQ-002 clk  input  1  single clock, rising-edge active.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op  input  1  0 = bitwise OR, 1 = bitwise AND.
REQ-007 req0_a, req0_b  input  16 each  operands of requester 0.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b  same widths and meanings for requester 1.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_id  output  1  requester that owns the result.
REQ-011 resp_out  output  16  result.
REQ-012 resp_ready  input  1  consumer takes the result this cycle.

Function
REQ-013 A single shared 16-bit OR/AND unit SHALL serve both requesters; exactly one operation is accepted per cycle at most.
REQ-014 States: IDLE (no result held) and HOLD (result held, resp_valid=1).
REQ-015 Accept-enable SHALL be (state==IDLE) or (state==HOLD and resp_ready).
REQ-016 reqN_ready SHALL be combinational: accept-enable and reqN_valid and grant==N; never both readies high.
REQ-017 Grant: only one valid -> that one; both valid -> the requester not granted last; at first tie after reset -> FIRST_PRIO.
REQ-018 Last-grant pointer SHALL update only on an accepted transfer (valid and ready).
REQ-019 On acceptance, result = a|b (op=0) or a&b (op=1) and the requester id SHALL be registered; resp_valid rises next cycle (latency 1).
REQ-020 IDLE -> HOLD on acceptance; HOLD -> IDLE on resp_ready with no acceptance; HOLD -> HOLD on resp_ready with simultaneous acceptance (back-to-back, one result per cycle).
REQ-021 In HOLD without resp_ready, resp_out and resp_id SHALL stay stable and no request SHALL be accepted.
REQ-022 Requester inputs are sampled only on the accepting edge; later operand changes SHALL NOT affect the held result.
REQ-023 A requester that drops valid before acceptance SHALL lose nothing and SHALL NOT move the pointer.
REQ-024 resp_ready while in IDLE SHALL be ignored.

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE, resp_valid=0, resp_id=0, resp_out=16'h0000, and pointer so that FIRST_PRIO wins the next tie.
REQ-026 Reset mid-HOLD SHALL discard the held result with no response delivered; req0_ready/req1_ready SHALL be 0 while reset is high.
REQ-027 Operation SHALL resume on the first rising edge after reset deasserts.

Structure
REQ-028 Shared package my_bitwise_pkg SHALL hold: WORD_W=16, op encoding (OP_OR=0, OP_AND=1), state enum (IDLE, HOLD).
REQ-029 Grant logic SHALL be one sub-module my_rr_arb_2 (two valids, pointer, accept in -> one-hot grant, pointer update).
REQ-030 The datapath SHALL reuse the existing my_or_16 for OR; AND SHALL be a 16-bit gate vector in the top level.

Verification
REQ-031 req0 only, op=0, a=16'hE000, b=16'h000C, resp_ready=1 -> req0_ready same cycle; next cycle resp_valid=1, resp_id=0, resp_out=16'hE00C.
REQ-032 Both valid after reset (FIRST_PRIO=0), req0 op=1 a=16'hFFFF b=16'h00F0, req1 op=0 a=16'h0000 b=16'hFFFF, resp_ready=1 -> results 16'h00F0 (id 0) then 16'hFFFF (id 1) on consecutive cycles.
REQ-033 Both valid held for 4 acceptances -> resp_id sequence 0,1,0,1.
REQ-034 resp_ready=0 for 3 cycles with a result held and both requesters valid -> resp_out/resp_id unchanged, both readies 0, no pointer move; raising resp_ready -> next result following cycle.
REQ-035 Reset pulsed while HOLD with resp_out=16'hA5A5 -> resp_valid=0 and resp_out=16'h0000 immediately, without a clock edge; after release a tie grants requester 0.
REQ-036 Operands changed the cycle after acceptance (a=16'h1111 -> 16'hFFFF) -> resp_out reflects 16'h1111 operation.
